// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    localparam int DEF_W_BIN   = 16;
    localparam int DEF_W_BCD   = 16;
    localparam int DEF_MAX_DEC = 9999;

    // Result reported when the converter never answers
    localparam logic [DEF_W_BCD-1:0] BCD_ERR = 16'hFFFF;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant,
    output logic             any_req
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N_REQ]) begin
                grant   = IW'((int'(ptr) + off) % N_REQ);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ requesters.
// Optional WAIT watchdog with a timeout output: define BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_BIN   = DEF_W_BIN,
    parameter int W_BCD   = DEF_W_BCD,
    parameter int MAX_DEC = DEF_MAX_DEC
`ifdef BCD_ARB_TIMEOUT_EN
    ,parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W_BIN-1:0] a_in,
    output logic [N_REQ-1:0]       res_valid,
    output logic [W_BCD-1:0]       res_bcd,
    output logic                   res_ovf,
    output logic                   busy,
    output logic                   dd_init,
    output logic [W_BIN-1:0]       dd_a,
    input  logic [W_BCD-1:0]       dd_c,
    input  logic                   dd_done
`ifdef BCD_ARB_TIMEOUT_EN
    ,output logic                  timeout
`endif
);

    localparam int IW = $clog2(N_REQ);

    state_t                      state, state_nx;
    logic [IW-1:0]               grant_q, rr_ptr, pick;
    logic                        any_req;
    logic [N_REQ-1:0][W_BIN-1:0] a_arr;
    logic                        done_q, done_edge, ovf_q;
    logic                        wd_hit;

    assign a_arr     = a_in;
    assign done_edge = dd_done & ~done_q;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wd_cnt;
    logic          to_q;

    assign wd_hit  = (state == WAIT) && (wd_cnt == CW'(TIMEOUT_CYC));
    assign timeout = (state == DELIVER) && to_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                wd_cnt <= '0;
        else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
        else                    wd_cnt <= '0;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        dd_init   = 1'b0;
        res_valid = '0;
        res_ovf   = 1'b0;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE: begin
                dd_init  = 1'b1;
                state_nx = WAIT;
            end
            // A done level left over from the previous conversion is not an edge
            WAIT:    if (done_edge || wd_hit) state_nx = DELIVER;
            DELIVER: begin
                res_valid[grant_q] = 1'b1;
                res_ovf            = ovf_q;
                state_nx           = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            rr_ptr  <= '0;
            dd_a    <= '0;
            ovf_q   <= 1'b0;
            res_bcd <= '0;
            busy    <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            done_q <= dd_done;
            case (state)
                IDLE: if (any_req) begin
                    grant_q <= pick;
                    dd_a    <= a_arr[pick];
                    ovf_q   <= a_arr[pick] > W_BIN'(MAX_DEC);
                    busy    <= 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
                    to_q    <= 1'b0;
`endif
                end
                WAIT: begin
                    if (done_edge) begin
                        res_bcd <= dd_c;
                    end
`ifdef BCD_ARB_TIMEOUT_EN
                    else if (wd_hit) begin
                        res_bcd <= W_BCD'(BCD_ERR);
                        ovf_q   <= 1'b1;
                        to_q    <= 1'b1;
                    end
`endif
                end
                DELIVER: begin
                    rr_ptr <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural double-dabble converter.
module tb_bcd_conv_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic [3:0][15:0] a_arr = '0;
    logic [3:0]       res_valid;
    logic [15:0]      res_bcd;
    logic             res_ovf, busy, dd_init;
    logic [15:0]      dd_a, dd_c;
    logic             dd_done;
`ifdef BCD_ARB_TIMEOUT_EN
    logic             timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(
        .N_REQ(4), .W_BIN(16), .W_BCD(16), .MAX_DEC(9999)
`ifdef BCD_ARB_TIMEOUT_EN
        ,.TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_arr),
        .res_valid(res_valid), .res_bcd(res_bcd), .res_ovf(res_ovf), .busy(busy),
        .dd_init(dd_init), .dd_a(dd_a), .dd_c(dd_c), .dd_done(dd_done)
`ifdef BCD_ARB_TIMEOUT_EN
        ,.timeout(timeout)
`endif
    );

    // Converter model: result after conv_lat cycles; hold=1 keeps done high
    // until the next conversion is about to finish.
    bit          conv_en  = 1'b1;
    bit          hold     = 1'b0;
    int          conv_lat = 5;
    int          cnt;
    bit          run;
    logic [15:0] pend;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_done <= 1'b0;
            dd_c    <= '0;
            run = 1'b0;
            cnt = 0;
        end else if (dd_init && conv_en) begin
            run  = 1'b1;
            cnt  = conv_lat;
            pend = to_bcd(int'(dd_a));
        end else if (run) begin
            cnt--;
            if (cnt == 1) dd_done <= 1'b0;
            if (cnt == 0) begin
                dd_c    <= pend;
                dd_done <= 1'b1;
                run = 1'b0;
            end
        end else if (!hold && dd_done) begin
            dd_done <= 1'b0;
        end
    end

    int          init_cnt = 0;
    logic [15:0] last_a   = '0;
    always @(negedge clk) if (!rst && dd_init) begin
        init_cnt++;
        last_a = dd_a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_deliver(input string nm, input logic [3:0] ev, input logic [15:0] eb,
                                  input logic eo, input bit drop, output int cyc);
        logic [3:0]  v;
        logic [15:0] b;
        logic        o;
        v = '0; b = '0; o = 1'b0; cyc = 0;
        while (cyc < 100 && v == '0) begin
            @(negedge clk);
            cyc++;
            if (res_valid != '0) begin
                v = res_valid; b = res_bcd; o = res_ovf;
            end
        end
        if (drop) req = req & ~ev;
        chk({nm, ".valid"}, 32'(v), 32'(ev));
        chk({nm, ".bcd"},   32'(b), 32'(eb));
        chk({nm, ".ovf"},   32'(o), 32'(eo));
        @(negedge clk);
        chk({nm, ".pulse"}, 32'(res_valid), 0);
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!dd_init && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".init"}, 32'(dd_init), 1);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [3:0]  ev;
        logic [15:0] eb;
        logic        eo;
    } vec_t;

    vec_t tbl[6];
    int   cyc, n0;

    initial begin
        tbl[0] = '{2, 16'd15,    4'b0100, 16'h0015, 1'b0};
        tbl[1] = '{1, 16'd9999,  4'b0010, 16'h9999, 1'b0};
        tbl[2] = '{3, 16'd10000, 4'b1000, 16'h0000, 1'b1};
        tbl[3] = '{0, 16'd0,     4'b0001, 16'h0000, 1'b0};
        tbl[4] = '{0, 16'd65535, 4'b0001, 16'h5535, 1'b1};
        tbl[5] = '{1, 16'd808,   4'b0010, 16'h0808, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(res_valid), 0);
        chk("rst.bcd",   32'(res_bcd),   0);
        chk("rst.ovf",   32'(res_ovf),   0);
        chk("rst.busy",  32'(busy),      0);
        chk("rst.init",  32'(dd_init),   0);
        chk("rst.dd_a",  32'(dd_a),      0);
        rst = 1'b0;
        @(negedge clk);

        // All four at once from rr_ptr=0, with first-grant latency
        a_arr[0] = 16'd39; a_arr[1] = 16'd1234; a_arr[2] = 16'd9999; a_arr[3] = 16'd7;
        req = 4'b1111;
        n0 = init_cnt;
        @(negedge clk);
        chk("all.init", 32'(dd_init), 1);
        chk("all.busy", 32'(busy), 1);
        chk("all.dd_a", 32'(dd_a), 39);
        expect_deliver("all0", 4'b0001, 16'h0039, 1'b0, 1'b1, cyc);
        chk("all0.lat", 32'(cyc), 7);
        expect_deliver("all1", 4'b0010, 16'h1234, 1'b0, 1'b1, cyc);
        expect_deliver("all2", 4'b0100, 16'h9999, 1'b0, 1'b1, cyc);
        expect_deliver("all3", 4'b1000, 16'h0007, 1'b0, 1'b1, cyc);
        chk("all.inits", 32'(init_cnt - n0), 4);
        chk("all.idle_busy", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            n0 = init_cnt;
            a_arr[tbl[i].idx] = tbl[i].a;
            req[tbl[i].idx]   = 1'b1;
            expect_deliver($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].eo, 1'b1, cyc);
            chk($sformatf("vec%0d.inits", i), 32'(init_cnt - n0), 1);
            chk($sformatf("vec%0d.dd_a", i),  32'(last_a), 32'(tbl[i].a));
        end

        // Fairness: req[0] held, req[3] raised during 0's WAIT
        a_arr[0] = 16'd100; a_arr[3] = 16'd3333;
        req[0] = 1'b1;
        wait_init("fair");
        @(negedge clk);
        req[3] = 1'b1;
        expect_deliver("fair0", 4'b0001, 16'h0100, 1'b0, 1'b0, cyc);
        a_arr[0] = 16'd200;
        expect_deliver("fair3", 4'b1000, 16'h3333, 1'b0, 1'b1, cyc);
        expect_deliver("fair0b", 4'b0001, 16'h0200, 1'b0, 1'b1, cyc);

        // Stale done: level held over must not end the next WAIT
        hold = 1'b1;
        a_arr[1] = 16'd42;
        req[1] = 1'b1;
        expect_deliver("stale1", 4'b0010, 16'h0042, 1'b0, 1'b1, cyc);
        a_arr[2] = 16'd777;
        req[2] = 1'b1;
        wait_init("stale2");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stale.early%0d", i), 32'(res_valid), 0);
        end
        a_arr[2] = 16'd1;
        expect_deliver("stale2", 4'b0100, 16'h0777, 1'b0, 1'b1, cyc);
        hold = 1'b0;
        repeat (2) @(negedge clk);

        // Overflow, then reset during another WAIT
        a_arr[2] = 16'd12345;
        req[2] = 1'b1;
        expect_deliver("ovf", 4'b0100, 16'h2345, 1'b1, 1'b1, cyc);
        a_arr[1] = 16'd500;
        req[1] = 1'b1;
        wait_init("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        a_arr[1] = 16'd600;
        @(negedge clk);
        chk("mid.valid", 32'(res_valid), 0);
        chk("mid.bcd",   32'(res_bcd),   0);
        chk("mid.busy",  32'(busy),      0);
        chk("mid.dd_a",  32'(dd_a),      0);
        chk("mid.init",  32'(dd_init),   0);
        rst = 1'b0;
        a_arr[3] = 16'd3000;
        req = 4'b1010;
        expect_deliver("post1", 4'b0010, 16'h0600, 1'b0, 1'b1, cyc);
        expect_deliver("post3", 4'b1000, 16'h3000, 1'b0, 1'b1, cyc);

`ifdef BCD_ARB_TIMEOUT_EN
        conv_en = 1'b0;
        a_arr[0] = 16'd5;
        req[0] = 1'b1;
        wait_init("wd");
        req[0] = 1'b0;
        cyc = 0;
        while (cyc < 100 && res_valid == '0) begin
            @(negedge clk);
            cyc++;
        end
        chk("wd.lat",   32'(cyc), 18);
        chk("wd.valid", 32'(res_valid), 32'(4'b0001));
        chk("wd.bcd",   32'(res_bcd), 32'(16'hFFFF));
        chk("wd.ovf",   32'(res_ovf), 1);
        chk("wd.flag",  32'(timeout), 1);
        @(negedge clk);
        chk("wd.flag_clr", 32'(timeout), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
